// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forwarding selects,
// stage-control bundle and common widths.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned REG_W   = 5;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned TIMER_W = 16;
  localparam int unsigned FCNT_W  = 3;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERROR    = 2'd3
  } state_e;

  typedef enum logic [SEL_W-1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

  // Per-cycle stage control decisions
  typedef struct packed {
    logic stall_fe;
    logic stall_de;
    logic bubble_ex;
    logic flush_de;
    logic hold_ex;
  } ctl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: stage status in, stall/flush/forward controls out.
interface pipe_hazard_ctrl_if
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
);
  logic [REG_W-1:0] de_rs1;
  logic [REG_W-1:0] de_rs2;
  logic             de_use_rs1;
  logic             de_use_rs2;
  logic             ex_valid;
  logic             ex_is_load;
  logic [REG_W-1:0] ex_rd;
  logic             mem_valid;
  logic [REG_W-1:0] mem_rd;
  logic             wb_valid;
  logic [REG_W-1:0] wb_rd;
  logic             redirect_valid;
  logic             mem_req;
  logic             mem_ready;

  logic             stall_fe;
  logic             stall_de;
  logic             bubble_ex;
  logic             flush_de;
  logic             hold_ex;
  logic [SEL_W-1:0] fwd_rs1_sel;
  logic [SEL_W-1:0] fwd_rs2_sel;
  logic             mem_timeout_err;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output de_rs1, de_rs2, de_use_rs1, de_use_rs2, ex_valid, ex_is_load, ex_rd,
           mem_valid, mem_rd, wb_valid, wb_rd, redirect_valid, mem_req, mem_ready,
    input  stall_fe, stall_de, bubble_ex, flush_de, hold_ex, fwd_rs1_sel, fwd_rs2_sel,
           mem_timeout_err, stall_count, flush_count
  );

  modport slave (
    input  de_rs1, de_rs2, de_use_rs1, de_use_rs2, ex_valid, ex_is_load, ex_rd,
           mem_valid, mem_rd, wb_valid, wb_rd, redirect_valid, mem_req, mem_ready,
    output stall_fe, stall_de, bubble_ex, flush_de, hold_ex, fwd_rs1_sel, fwd_rs2_sel,
           mem_timeout_err, stall_count, flush_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd_sel_unit.sv
// Operand bypass select for one decode source register; nearest producing stage wins.
module fwd_sel_unit
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] rs_i,
  input  logic             use_i,
  input  logic             ex_valid_i,
  input  logic             ex_is_load_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             mem_valid_i,
  input  logic [REG_W-1:0] mem_rd_i,
  input  logic             wb_valid_i,
  input  logic [REG_W-1:0] wb_rd_i,
  output fwd_sel_e         sel_o
);

  // Load data is not ready in EX, so a load never forwards from there
  always_comb begin
    sel_o = FWD_RF;
    if (use_i && (rs_i != '0)) begin
      if (ex_valid_i && !ex_is_load_i && (ex_rd_i == rs_i)) begin
        sel_o = FWD_EX;
      end else if (mem_valid_i && (mem_rd_i == rs_i)) begin
        sel_o = FWD_MEM;
      end else if (wb_valid_i && (wb_rd_i == rs_i)) begin
        sel_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stall/bubble/flush/hold decisions, operand forwarding selects,
// redirect flush and data-memory wait sequencing, saturating stall/flush statistics.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REDIRECT_FLUSH_CYCLES = 2,
  parameter int unsigned MEM_TIMEOUT           = 255,
  parameter int unsigned CNT_W                 = 32
) (
  input logic              clk,
  input logic              rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [FCNT_W-1:0]  FLUSH_FULL = FCNT_W'(REDIRECT_FLUSH_CYCLES);
  localparam logic [FCNT_W-1:0]  FLUSH_REST = FCNT_W'(REDIRECT_FLUSH_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT    = TIMER_W'(MEM_TIMEOUT);

  state_e             state_q, state_d;
  logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               pend_q, pend_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  ctl_t     ctl_c;
  logic     stall_inc_c;
  logic     flush_inc_c;
  logic     mem_wait_c;
  logic     load_use_c;
  fwd_sel_e fwd1_c, fwd2_c;

  fwd_sel_unit u_fwd_rs1 (
    .rs_i        (bus.de_rs1),
    .use_i       (bus.de_use_rs1),
    .ex_valid_i  (bus.ex_valid),
    .ex_is_load_i(bus.ex_is_load),
    .ex_rd_i     (bus.ex_rd),
    .mem_valid_i (bus.mem_valid),
    .mem_rd_i    (bus.mem_rd),
    .wb_valid_i  (bus.wb_valid),
    .wb_rd_i     (bus.wb_rd),
    .sel_o       (fwd1_c)
  );

  fwd_sel_unit u_fwd_rs2 (
    .rs_i        (bus.de_rs2),
    .use_i       (bus.de_use_rs2),
    .ex_valid_i  (bus.ex_valid),
    .ex_is_load_i(bus.ex_is_load),
    .ex_rd_i     (bus.ex_rd),
    .mem_valid_i (bus.mem_valid),
    .mem_rd_i    (bus.mem_rd),
    .wb_valid_i  (bus.wb_valid),
    .wb_rd_i     (bus.wb_rd),
    .sel_o       (fwd2_c)
  );

  assign mem_wait_c = bus.mem_req && !bus.mem_ready;
  assign load_use_c = bus.ex_valid && bus.ex_is_load && (bus.ex_rd != '0) &&
                      ((bus.de_use_rs1 && (bus.de_rs1 == bus.ex_rd)) ||
                       (bus.de_use_rs2 && (bus.de_rs2 == bus.ex_rd)));

  // Next state and per-cycle stage controls
  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    timer_d     = timer_q;
    pend_d      = pend_q;
    ctl_c       = '0;
    stall_inc_c = 1'b0;
    flush_inc_c = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_wait_c) begin
          ctl_c.stall_fe = 1'b1;
          ctl_c.stall_de = 1'b1;
          ctl_c.hold_ex  = 1'b1;
          stall_inc_c    = 1'b1;
          timer_d        = TIMER_W'(1);
          state_d        = ST_MEM_WAIT;
        end else if (bus.redirect_valid) begin
          ctl_c.flush_de  = 1'b1;
          ctl_c.bubble_ex = 1'b1;
          flush_inc_c     = 1'b1;
          if (REDIRECT_FLUSH_CYCLES > 1) begin
            state_d = ST_FLUSH;
            fcnt_d  = FLUSH_REST;
          end
        end else if (load_use_c) begin
          ctl_c.stall_fe  = 1'b1;
          ctl_c.stall_de  = 1'b1;
          ctl_c.bubble_ex = 1'b1;
          stall_inc_c     = 1'b1;
        end
      end
      ST_FLUSH: begin
        ctl_c.flush_de  = 1'b1;
        ctl_c.bubble_ex = 1'b1;
        if (mem_wait_c) begin
          ctl_c.stall_fe = 1'b1;
          ctl_c.stall_de = 1'b1;
          ctl_c.hold_ex  = 1'b1;
          stall_inc_c    = 1'b1;
        end else if (fcnt_q <= FCNT_W'(1)) begin
          fcnt_d  = '0;
          state_d = ST_RUN;
        end else begin
          fcnt_d = fcnt_q - FCNT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        // A redirect seen while held (or on the release cycle) becomes a full flush
        if (bus.mem_ready) begin
          if (pend_q || bus.redirect_valid) begin
            state_d     = ST_FLUSH;
            fcnt_d      = FLUSH_FULL;
            flush_inc_c = 1'b1;
            pend_d      = 1'b0;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          ctl_c.stall_fe = 1'b1;
          ctl_c.stall_de = 1'b1;
          ctl_c.hold_ex  = 1'b1;
          stall_inc_c    = 1'b1;
          if (bus.redirect_valid) begin
            pend_d = 1'b1;
          end
          if (timer_q >= TIMEOUT) begin
            state_d = ST_ERROR;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
      end
      ST_ERROR: begin
        ctl_c.stall_fe = 1'b1;
        ctl_c.stall_de = 1'b1;
        ctl_c.hold_ex  = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign stall_cnt_d = (stall_inc_c && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  assign flush_cnt_d = (flush_inc_c && (flush_cnt_q != '1)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      fcnt_q      <= '0;
      timer_q     <= '0;
      pend_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      timer_q     <= timer_d;
      pend_q      <= pend_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Controls are forced quiet while reset is held
  assign bus.stall_fe        = rst_n && ctl_c.stall_fe;
  assign bus.stall_de        = rst_n && ctl_c.stall_de;
  assign bus.bubble_ex       = rst_n && ctl_c.bubble_ex;
  assign bus.flush_de        = rst_n && ctl_c.flush_de;
  assign bus.hold_ex         = rst_n && ctl_c.hold_ex;
  assign bus.fwd_rs1_sel     = rst_n ? fwd1_c : FWD_RF;
  assign bus.fwd_rs2_sel     = rst_n ? fwd2_c : FWD_RF;
  assign bus.mem_timeout_err = rst_n && (state_q == ST_ERROR);
  assign bus.stall_count     = stall_cnt_q;
  assign bus.flush_count     = flush_cnt_q;

endmodule
